// File: rtl/l1v_onbellek_pkg.sv
// Shared widths, FSM state type and byte-merge helper for the l1v data cache.
// Imported by l1v_etiket_dizisi and l1v_onbellek.
package l1v_onbellek_pkg;

  localparam int ADRES_BIT = 32;
  localparam int VERI_BIT  = 32;
  localparam int VERI_BYTE = VERI_BIT / 8;

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    YANIT     = 2'd1,
    BEL_ISTEK = 2'd2,
    BEL_BEKLE = 2'd3
  } durum_t;

  function automatic logic [VERI_BIT-1:0] bayt_birlestir(
    input logic [VERI_BIT-1:0]  eski,
    input logic [VERI_BIT-1:0]  yeni,
    input logic [VERI_BYTE-1:0] maske
  );
    logic [VERI_BIT-1:0] r;
    r = eski;
    for (int b = 0; b < VERI_BYTE; b++) begin
      if (maske[b]) r[8*b +: 8] = yeni[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1v_etiket_dizisi.sv
// Valid/tag/data flop arrays: combinational lookup, synchronous fill,
// masked byte write at the lookup index, invalidate-all on rst_i.
// Ports: clk_i, rst_i, lookup (indeks/etiket -> isabet/oku_veri),
// yaz_* masked write, dolum_* line fill.
module l1v_etiket_dizisi
  import l1v_onbellek_pkg::*;
#(
  parameter int SATIR_SAYISI = 64,
  localparam int IB = $clog2(SATIR_SAYISI),
  localparam int EB = ADRES_BIT - 2 - IB
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IB-1:0]        indeks,
  input  logic [EB-1:0]        etiket,
  output logic                 isabet,
  output logic [VERI_BIT-1:0]  oku_veri,
  input  logic                 yaz_en,
  input  logic [VERI_BIT-1:0]  yaz_veri,
  input  logic [VERI_BYTE-1:0] yaz_maske,
  input  logic                 dolum_en,
  input  logic [IB-1:0]        dolum_indeks,
  input  logic [EB-1:0]        dolum_etiket,
  input  logic [VERI_BIT-1:0]  dolum_veri
);

  logic [SATIR_SAYISI-1:0] gecerli;
  logic [EB-1:0]           etiketler [SATIR_SAYISI];
  logic [VERI_BIT-1:0]     veriler   [SATIR_SAYISI];

  assign isabet   = gecerli[indeks] &&
                    (etiketler[indeks] == etiket);
  assign oku_veri = veriler[indeks];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gecerli <= '0;
    end else if (dolum_en) begin
      gecerli[dolum_indeks] <= 1'b1;
    end
  end

  // Fill and store-hit write never occur in the same cycle
  // (different FSM states); fill is given priority anyway.
  always_ff @(posedge clk_i) begin
    if (dolum_en) begin
      etiketler[dolum_indeks] <= dolum_etiket;
      veriler[dolum_indeks]   <= dolum_veri;
    end else if (yaz_en) begin
      veriler[indeks] <= bayt_birlestir(
        veriler[indeks], yaz_veri, yaz_maske);
    end
  end

endmodule

// File: rtl/l1v_onbellek.sv
// Direct-mapped write-through no-write-allocate L1 data cache.
// Ports: l1v_istek_*/l1v_veri_* core side, bel_* memory side;
// `L1V_SAYAC_EN adds isabet_sayisi_o / iska_sayisi_o load counters.
module l1v_onbellek
  import l1v_onbellek_pkg::*;
#(
  parameter int SATIR_SAYISI = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] l1v_istek_adres_i,
  input  logic                 l1v_istek_gecerli_i,
  input  logic                 l1v_istek_onbellekleme_i,
  input  logic                 l1v_istek_yaz_i,
  input  logic [VERI_BIT-1:0]  l1v_istek_veri_i,
  input  logic [VERI_BYTE-1:0] l1v_istek_maske_i,
  output logic                 l1v_istek_hazir_o,
  output logic [VERI_BIT-1:0]  l1v_veri_o,
  output logic                 l1v_veri_gecerli_o,
  input  logic                 l1v_veri_hazir_i,
  output logic [ADRES_BIT-1:0] bel_istek_adres_o,
  output logic                 bel_istek_gecerli_o,
  output logic                 bel_istek_yaz_o,
  output logic [VERI_BIT-1:0]  bel_istek_veri_o,
  output logic [VERI_BYTE-1:0] bel_istek_maske_o,
  input  logic                 bel_istek_hazir_i,
  input  logic [VERI_BIT-1:0]  bel_veri_i,
  input  logic                 bel_veri_gecerli_i,
  output logic                 bel_veri_hazir_o
`ifdef L1V_SAYAC_EN
  ,
  output logic [31:0]          isabet_sayisi_o,
  output logic [31:0]          iska_sayisi_o
`endif
);

  localparam int IB = $clog2(SATIR_SAYISI);
  localparam int EB = ADRES_BIT - 2 - IB;

  durum_t durum_q, durum_d;

  logic [ADRES_BIT-1:2] adres_q;
  logic                 yaz_q;
  logic                 onb_q;
  logic [VERI_BIT-1:0]  veri_q;
  logic [VERI_BYTE-1:0] maske_q;
  logic [VERI_BIT-1:0]  yanit_q;

  logic                isabet;
  logic [VERI_BIT-1:0] dizi_veri;
  logic                kabul;
  logic                okuma_isabet;
  logic                yazma_isabet;
  logic                dolum;
  logic                bayt_unused;

  // Byte offset plays no part in a word-per-line cache.
  assign bayt_unused = ^l1v_istek_adres_i[1:0];

  assign kabul = l1v_istek_gecerli_i &&
                 (durum_q == BOSTA) && !rst_i;

  assign okuma_isabet = kabul && !l1v_istek_yaz_i &&
                        l1v_istek_onbellekleme_i && isabet;

  assign yazma_isabet = kabul && l1v_istek_yaz_i &&
                        l1v_istek_onbellekleme_i && isabet;

  assign dolum = (durum_q == BEL_BEKLE) &&
                 bel_veri_gecerli_i && onb_q && !rst_i;

  l1v_etiket_dizisi #(
    .SATIR_SAYISI(SATIR_SAYISI)
  ) u_dizi (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .indeks       (l1v_istek_adres_i[2 +: IB]),
    .etiket       (l1v_istek_adres_i[ADRES_BIT-1 -: EB]),
    .isabet       (isabet),
    .oku_veri     (dizi_veri),
    .yaz_en       (yazma_isabet),
    .yaz_veri     (l1v_istek_veri_i),
    .yaz_maske    (l1v_istek_maske_i),
    .dolum_en     (dolum),
    .dolum_indeks (adres_q[2 +: IB]),
    .dolum_etiket (adres_q[ADRES_BIT-1 -: EB]),
    .dolum_veri   (bel_veri_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  always_comb begin
    durum_d             = durum_q;
    l1v_istek_hazir_o   = 1'b0;
    l1v_veri_gecerli_o  = 1'b0;
    bel_istek_gecerli_o = 1'b0;
    bel_veri_hazir_o    = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        l1v_istek_hazir_o = 1'b1;
        // Late memory responses land here and are dropped.
        bel_veri_hazir_o  = 1'b1;
        if (l1v_istek_gecerli_i) begin
          durum_d = okuma_isabet ? YANIT : BEL_ISTEK;
        end
      end
      BEL_ISTEK: begin
        bel_istek_gecerli_o = 1'b1;
        if (bel_istek_hazir_i) begin
          durum_d = yaz_q ? BOSTA : BEL_BEKLE;
        end
      end
      BEL_BEKLE: begin
        bel_veri_hazir_o = 1'b1;
        if (bel_veri_gecerli_i) durum_d = YANIT;
      end
      YANIT: begin
        l1v_veri_gecerli_o = 1'b1;
        if (l1v_veri_hazir_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adres_q <= '0;
      yaz_q   <= 1'b0;
      onb_q   <= 1'b0;
      veri_q  <= '0;
      maske_q <= '0;
      yanit_q <= '0;
    end else begin
      if (kabul) begin
        adres_q <= l1v_istek_adres_i[ADRES_BIT-1:2];
        yaz_q   <= l1v_istek_yaz_i;
        onb_q   <= l1v_istek_onbellekleme_i;
        veri_q  <= l1v_istek_veri_i;
        maske_q <= l1v_istek_yaz_i ?
                   l1v_istek_maske_i : '1;
      end
      if (okuma_isabet) begin
        yanit_q <= dizi_veri;
      end else if ((durum_q == BEL_BEKLE) &&
                   bel_veri_gecerli_i) begin
        yanit_q <= bel_veri_i;
      end
    end
  end

  assign l1v_veri_o        = yanit_q;
  assign bel_istek_adres_o = {adres_q, 2'b00};
  assign bel_istek_yaz_o   = yaz_q;
  assign bel_istek_veri_o  = veri_q;
  assign bel_istek_maske_o = maske_q;

`ifdef L1V_SAYAC_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      isabet_sayisi_o <= '0;
      iska_sayisi_o   <= '0;
    end else if (kabul && !l1v_istek_yaz_i &&
                 l1v_istek_onbellekleme_i) begin
      if (isabet) isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
      else        iska_sayisi_o   <= iska_sayisi_o + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_l1v_onbellek.sv
// Self-checking bench for l1v_onbellek: directed scenarios then
// randomized loads/stores against a behavioural cache/memory model.
module tb_l1v_onbellek;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] l1v_istek_adres_i;
  logic        l1v_istek_gecerli_i;
  logic        l1v_istek_onbellekleme_i;
  logic        l1v_istek_yaz_i;
  logic [31:0] l1v_istek_veri_i;
  logic [3:0]  l1v_istek_maske_i;
  logic        l1v_istek_hazir_o;
  logic [31:0] l1v_veri_o;
  logic        l1v_veri_gecerli_o;
  logic        l1v_veri_hazir_i;
  logic [31:0] bel_istek_adres_o;
  logic        bel_istek_gecerli_o;
  logic        bel_istek_yaz_o;
  logic [31:0] bel_istek_veri_o;
  logic [3:0]  bel_istek_maske_o;
  logic        bel_istek_hazir_i;
  logic [31:0] bel_veri_i;
  logic        bel_veri_gecerli_i;
  logic        bel_veri_hazir_o;
`ifdef L1V_SAYAC_EN
  logic [31:0] isabet_sayisi_o;
  logic [31:0] iska_sayisi_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [int unsigned];
  bit          m_val [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_dat [64];

  l1v_onbellek dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .l1v_istek_adres_i        (l1v_istek_adres_i),
    .l1v_istek_gecerli_i      (l1v_istek_gecerli_i),
    .l1v_istek_onbellekleme_i (l1v_istek_onbellekleme_i),
    .l1v_istek_yaz_i          (l1v_istek_yaz_i),
    .l1v_istek_veri_i         (l1v_istek_veri_i),
    .l1v_istek_maske_i        (l1v_istek_maske_i),
    .l1v_istek_hazir_o        (l1v_istek_hazir_o),
    .l1v_veri_o               (l1v_veri_o),
    .l1v_veri_gecerli_o       (l1v_veri_gecerli_o),
    .l1v_veri_hazir_i         (l1v_veri_hazir_i),
    .bel_istek_adres_o        (bel_istek_adres_o),
    .bel_istek_gecerli_o      (bel_istek_gecerli_o),
    .bel_istek_yaz_o          (bel_istek_yaz_o),
    .bel_istek_veri_o         (bel_istek_veri_o),
    .bel_istek_maske_o        (bel_istek_maske_o),
    .bel_istek_hazir_i        (bel_istek_hazir_i),
    .bel_veri_i               (bel_veri_i),
    .bel_veri_gecerli_i       (bel_veri_gecerli_i),
    .bel_veri_hazir_o         (bel_veri_hazir_o)
`ifdef L1V_SAYAC_EN
    ,
    .isabet_sayisi_o          (isabet_sayisi_o),
    .iska_sayisi_o            (iska_sayisi_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mem_oku(logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] birlestir(
    logic [31:0] eski, logic [31:0] yeni, logic [3:0] m);
    logic [31:0] r;
    r = eski;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = yeni[8*b +: 8];
    return r;
  endfunction

  function automatic bit model_isabet(logic [31:0] a);
    int i;
    i = int'((a >> 2) % 64);
    return m_val[i] && (m_tag[i] == a[31:8]);
  endfunction

  task automatic model_sifirla();
    for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
  endtask

  task automatic yukle(input logic [31:0] a, input bit onb,
                       input int bh, input int mg, input int vh);
    logic [31:0] beklenen;
    bit          hit;
    int          i;
    i   = int'((a >> 2) % 64);
    hit = onb && model_isabet(a);
    chk("ld_hazir", l1v_istek_hazir_o, 1'b1);
    l1v_istek_adres_i        = a;
    l1v_istek_onbellekleme_i = onb;
    l1v_istek_yaz_i          = 1'b0;
    l1v_istek_veri_i         = $urandom;
    l1v_istek_maske_i        = 4'($urandom);
    l1v_istek_gecerli_i      = 1'b1;
    tick();
    l1v_istek_gecerli_i = 1'b0;
    l1v_istek_adres_i   = $urandom;
    if (hit) begin
      beklenen = m_dat[i];
    end else begin
      chk("ld_bel_gecerli", bel_istek_gecerli_o, 1'b1);
      chk("ld_bel_adres", bel_istek_adres_o, a & 32'hFFFF_FFFC);
      chk("ld_bel_yaz", bel_istek_yaz_o, 1'b0);
      chk("ld_bel_maske", bel_istek_maske_o, 4'hF);
      for (int k = 0; k < bh; k++) begin
        tick();
        chk("ld_bel_tut", bel_istek_gecerli_o, 1'b1);
        chk("ld_bel_adres_tut", bel_istek_adres_o,
            a & 32'hFFFF_FFFC);
        chk("ld_mesgul", l1v_istek_hazir_o, 1'b0);
      end
      bel_istek_hazir_i = 1'b1;
      tick();
      bel_istek_hazir_i = 1'b0;
      chk("ld_bel_bitti", bel_istek_gecerli_o, 1'b0);
      for (int k = 0; k < mg; k++) begin
        chk("ld_bekle", l1v_veri_gecerli_o, 1'b0);
        tick();
      end
      chk("ld_bel_veri_hazir", bel_veri_hazir_o, 1'b1);
      beklenen = onb ? mem_oku(a) : $urandom;
      bel_veri_i         = beklenen;
      bel_veri_gecerli_i = 1'b1;
      tick();
      bel_veri_gecerli_i = 1'b0;
      bel_veri_i         = $urandom;
      if (onb) begin
        m_val[i] = 1'b1;
        m_tag[i] = a[31:8];
        m_dat[i] = beklenen;
      end
    end
    chk("ld_veri_gecerli", l1v_veri_gecerli_o, 1'b1);
    chk("ld_veri", l1v_veri_o, beklenen);
    chk("ld_bel_yok", bel_istek_gecerli_o, 1'b0);
    for (int k = 0; k < vh; k++) begin
      tick();
      chk("ld_yanit_tut", l1v_veri_gecerli_o, 1'b1);
      chk("ld_veri_tut", l1v_veri_o, beklenen);
    end
    l1v_veri_hazir_i = 1'b1;
    tick();
    l1v_veri_hazir_i = 1'b0;
    chk("ld_son_gecerli", l1v_veri_gecerli_o, 1'b0);
    chk("ld_son_hazir", l1v_istek_hazir_o, 1'b1);
  endtask

  task automatic sakla(input logic [31:0] a, input bit onb,
                       input logic [31:0] d, input logic [3:0] m,
                       input int bh);
    int i;
    i = int'((a >> 2) % 64);
    chk("st_hazir", l1v_istek_hazir_o, 1'b1);
    l1v_istek_adres_i        = a;
    l1v_istek_onbellekleme_i = onb;
    l1v_istek_yaz_i          = 1'b1;
    l1v_istek_veri_i         = d;
    l1v_istek_maske_i        = m;
    l1v_istek_gecerli_i      = 1'b1;
    tick();
    l1v_istek_gecerli_i = 1'b0;
    l1v_istek_veri_i    = $urandom;
    mem[a >> 2] = birlestir(mem_oku(a), d, m);
    if (onb && model_isabet(a)) m_dat[i] = birlestir(m_dat[i], d, m);
    for (int k = 0; k <= bh; k++) begin
      chk("st_bel_gecerli", bel_istek_gecerli_o, 1'b1);
      chk("st_bel_yaz", bel_istek_yaz_o, 1'b1);
      chk("st_bel_adres", bel_istek_adres_o, a & 32'hFFFF_FFFC);
      chk("st_bel_veri", bel_istek_veri_o, d);
      chk("st_bel_maske", bel_istek_maske_o, m);
      chk("st_yanit_yok", l1v_veri_gecerli_o, 1'b0);
      if (k < bh) tick();
    end
    bel_istek_hazir_i = 1'b1;
    tick();
    bel_istek_hazir_i = 1'b0;
    chk("st_son_bel", bel_istek_gecerli_o, 1'b0);
    chk("st_son_hazir", l1v_istek_hazir_o, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    bit          onb;
    rst_i                    = 1'b1;
    l1v_istek_adres_i        = '0;
    l1v_istek_gecerli_i      = 1'b0;
    l1v_istek_onbellekleme_i = 1'b1;
    l1v_istek_yaz_i          = 1'b0;
    l1v_istek_veri_i         = '0;
    l1v_istek_maske_i        = '0;
    l1v_veri_hazir_i         = 1'b0;
    bel_istek_hazir_i        = 1'b0;
    bel_veri_i               = '0;
    bel_veri_gecerli_i       = 1'b0;
    model_sifirla();
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    tick();
    tick();
    rst_i = 1'b0;

    chk("rst_hazir", l1v_istek_hazir_o, 1'b1);
    chk("rst_veri_gecerli", l1v_veri_gecerli_o, 1'b0);
    chk("rst_bel_gecerli", bel_istek_gecerli_o, 1'b0);
    chk("rst_bel_veri_hazir", bel_veri_hazir_o, 1'b1);
    chk("rst_veri", l1v_veri_o, 32'h0);
    chk("rst_bel_adres", bel_istek_adres_o, 32'h0);
    chk("rst_bel_wdata", bel_istek_veri_o, 32'h0);
`ifdef L1V_SAYAC_EN
    chk("rst_isabet", isabet_sayisi_o, 32'h0);
    chk("rst_iska", iska_sayisi_o, 32'h0);
`endif

    yukle(32'h100, 1'b1, 0, 1, 0);
    chk("ilk_veri", l1v_veri_o, 32'hDEAD_BEEF);
    yukle(32'h100, 1'b1, 0, 0, 0);
    sakla(32'h100, 1'b1, 32'h0000_00AA, 4'b0001, 0);
    yukle(32'h100, 1'b1, 0, 0, 0);
    chk("birlesik_veri", l1v_veri_o, 32'hDEAD_BEAA);

    yukle(32'h100, 1'b0, 0, 0, 0);
    yukle(32'h100, 1'b1, 0, 0, 0);
    chk("mmio_sonrasi", l1v_veri_o, 32'hDEAD_BEAA);

    yukle(32'h344, 1'b1, 3, 2, 5);
    sakla(32'h348, 1'b1, 32'h1234_5678, 4'b1100, 3);

    sakla(32'h200, 1'b1, 32'hCAFE_F00D, 4'b1111, 0);
    yukle(32'h200, 1'b1, 0, 1, 0);
    chk("st_miss_yukle", l1v_veri_o, 32'hCAFE_F00D);

    yukle(32'h100, 1'b1, 0, 0, 0);
    l1v_istek_adres_i        = 32'h180;
    l1v_istek_onbellekleme_i = 1'b1;
    l1v_istek_yaz_i          = 1'b0;
    l1v_istek_gecerli_i      = 1'b1;
    tick();
    l1v_istek_gecerli_i = 1'b0;
    chk("rb_bel_gecerli", bel_istek_gecerli_o, 1'b1);
    bel_istek_hazir_i = 1'b1;
    tick();
    bel_istek_hazir_i = 1'b0;
    chk("rb_bekle_hazir", bel_veri_hazir_o, 1'b1);
    chk("rb_mesgul", l1v_istek_hazir_o, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_sifirla();
    chk("rb_rst_hazir", l1v_istek_hazir_o, 1'b1);
    chk("rb_rst_bel", bel_istek_gecerli_o, 1'b0);
    bel_veri_i         = 32'hBAD0_BAD0;
    bel_veri_gecerli_i = 1'b1;
    tick();
    bel_veri_gecerli_i = 1'b0;
    chk("rb_gec_yanit", l1v_veri_gecerli_o, 1'b0);
    chk("rb_gec_hazir", l1v_istek_hazir_o, 1'b1);
`ifdef L1V_SAYAC_EN
    chk("rb_isabet", isabet_sayisi_o, 32'h0);
    chk("rb_iska", iska_sayisi_o, 32'h0);
`endif
    yukle(32'h100, 1'b1, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      a = 32'(($urandom_range(0, 2) << 8) |
              ($urandom_range(0, 7) << 2) |
              $urandom_range(0, 3));
      onb = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 3)
        sakla(a, onb, $urandom, 4'($urandom_range(1, 15)),
              $urandom_range(0, 2));
      else
        yukle(a, onb, $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
